// File: rtl/boot68k_bridge_pkg.sv
// Shared Neo Geo constants for the 68k boot-ROM bridge: FSM encodings, the
// default boot window base address and a counter-width helper.
package boot68k_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_ACK  = 3'd3,
      ST_HOLD = 3'd4
   } bridge_state_e;

   localparam logic [23:0] NG_BOOT_BASE = 24'hC00000;

   // Bits needed to hold a count up to and including limit.
   function automatic int cnt_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous 68k bus signal; both flops reset
// to RESET_VAL so a strobe reads as inactive straight out of reset.
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/boot68k_bridge.sv
// Bridges 68k bus reads in the boot window to a synchronous boot ROM; writes
// to the window are acknowledged and dropped, misses are left to other decoders.
module boot68k_bridge
   import boot68k_bridge_pkg::*;
#(
   parameter logic [23:0] BASE_ADDR = NG_BOOT_BASE,
   parameter int          ADDR_BITS = 10,
   parameter int          TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m68k_as_n,
   input  logic        m68k_uds_n,
   input  logic        m68k_lds_n,
   input  logic        m68k_rw,
   input  logic [22:0] m68k_addr,
   output logic [15:0] m68k_dout,
   output logic        m68k_doe,
   output logic        m68k_dtack_n,
   output logic        m68k_berr_n,
   output logic        wr_ignored,
   output logic        bootreq,
   output logic [15:0] bootaddr,
   input  logic        bootack,
   input  logic [15:0] bootdata
);

   localparam int               CNT_W    = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic as_s, uds_s, lds_s, rw_s;

   sync2 #(.RESET_VAL(1'b1)) u_sync_as  (.clk(clk), .rst_n(rst_n), .d(m68k_as_n),  .q(as_s));
   sync2 #(.RESET_VAL(1'b1)) u_sync_uds (.clk(clk), .rst_n(rst_n), .d(m68k_uds_n), .q(uds_s));
   sync2 #(.RESET_VAL(1'b1)) u_sync_lds (.clk(clk), .rst_n(rst_n), .d(m68k_lds_n), .q(lds_s));
   sync2 #(.RESET_VAL(1'b1)) u_sync_rw  (.clk(clk), .rst_n(rst_n), .d(m68k_rw),    .q(rw_s));

   bridge_state_e    state_q, state_d;
   logic             as_prev_q, as_prev_d;
   logic             abort_q, abort_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bootreq_q, bootreq_d;
   logic [15:0]      bootaddr_q, bootaddr_d;
   logic [15:0]      dout_q, dout_d;
   logic             doe_q, doe_d;
   logic             dtack_n_q, dtack_n_d;
   logic             berr_n_q, berr_n_d;
   logic             wr_ignored_q, wr_ignored_d;

   logic as_fall, hit, start_rd, start_wr, aborted, timed_out;

   // The raw address is only trusted once the synced strobe says it is stable.
   always_comb begin
      as_fall   = as_prev_q & ~as_s;
      hit       = ~as_s & (~uds_s | ~lds_s) &
                  (m68k_addr[22:ADDR_BITS] == BASE_ADDR[23:ADDR_BITS+1]);
      start_rd  = as_fall & hit & rw_s;
      start_wr  = as_fall & hit & ~rw_s;
      aborted   = abort_q | as_s;
      timed_out = (cnt_q == CNT_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_rd)      state_d = ST_REQ;
            else if (start_wr) state_d = ST_ACK;
         end
         ST_REQ:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (bootack || timed_out) state_d = aborted ? ST_IDLE : (bootack ? ST_ACK : ST_HOLD);
         end
         ST_ACK:  state_d = ST_HOLD;
         ST_HOLD: begin
            if (as_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus outputs are registered on the edge that enters ACK/HOLD, so DTACK
   // lands two cycles after bootreq and stays put until HOLD sees AS high.
   always_comb begin
      as_prev_d    = as_s;
      abort_d      = abort_q;
      cnt_d        = '0;
      bootreq_d    = 1'b0;
      wr_ignored_d = 1'b0;
      bootaddr_d   = bootaddr_q;
      dout_d       = dout_q;
      doe_d        = doe_q;
      dtack_n_d    = dtack_n_q;
      berr_n_d     = berr_n_q;
      case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (start_rd) begin
               bootreq_d  = 1'b1;
               bootaddr_d = 16'(m68k_addr[ADDR_BITS-1:0]);
            end else if (start_wr) begin
               wr_ignored_d = 1'b1;
               dtack_n_d    = 1'b0;
               doe_d        = 1'b0;
            end
         end
         ST_REQ: begin
            cnt_d   = cnt_q + 1'b1;
            abort_d = aborted;
         end
         ST_WAIT: begin
            cnt_d   = cnt_q + 1'b1;
            abort_d = aborted;
            if (bootack) begin
               if (!aborted) begin
                  dout_d    = bootdata;
                  doe_d     = 1'b1;
                  dtack_n_d = 1'b0;
               end
            end else if (timed_out && !aborted) begin
               berr_n_d = 1'b0;
            end
         end
         ST_HOLD: begin
            if (as_s) begin
               dtack_n_d = 1'b1;
               doe_d     = 1'b0;
               berr_n_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         as_prev_q    <= 1'b1;
         abort_q      <= 1'b0;
         cnt_q        <= '0;
         bootreq_q    <= 1'b0;
         wr_ignored_q <= 1'b0;
         bootaddr_q   <= '0;
         dout_q       <= '0;
         doe_q        <= 1'b0;
         dtack_n_q    <= 1'b1;
         berr_n_q     <= 1'b1;
      end else begin
         as_prev_q    <= as_prev_d;
         abort_q      <= abort_d;
         cnt_q        <= cnt_d;
         bootreq_q    <= bootreq_d;
         wr_ignored_q <= wr_ignored_d;
         bootaddr_q   <= bootaddr_d;
         dout_q       <= dout_d;
         doe_q        <= doe_d;
         dtack_n_q    <= dtack_n_d;
         berr_n_q     <= berr_n_d;
      end
   end

   assign bootreq      = bootreq_q;
   assign bootaddr     = bootaddr_q;
   assign m68k_dout    = dout_q;
   assign m68k_doe     = doe_q;
   assign m68k_dtack_n = dtack_n_q;
   assign m68k_berr_n  = berr_n_q;
   assign wr_ignored   = wr_ignored_q;

endmodule
